// File: rtl/bcast_tracker_dispatch.sv
// Broadcast-hub A-channel dispatcher: routes each message to one tracker,
// blocks same-line hazards, locks the target for multi-beat bursts.
// Ports: clock, reset (async, active-low); in_a_* client beat handshake
// plus opcode/size/address; trk_a_valid/trk_a_ready per-tracker routing;
// trk_a_first first-beat flag; trk_idle/trk_line tracker status; sel_oh
// current target. Optional (BCAST_DISPATCH_STALL_CNT_EN): stall_cnt[15:0].
module bcast_tracker_dispatch #(
  parameter int N_TRK     = 4,
  parameter int ADDR_W    = 33,
  parameter int LINE_OFF  = 6,
  parameter int BEAT_LOG2 = 3
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_a_valid,
  output logic                              in_a_ready,
  input  logic [2:0]                        in_a_opcode,
  input  logic [2:0]                        in_a_size,
  input  logic [ADDR_W-1:0]                 in_a_address,
  output logic [N_TRK-1:0]                  trk_a_valid,
  input  logic [N_TRK-1:0]                  trk_a_ready,
  output logic                              trk_a_first,
  input  logic [N_TRK-1:0]                  trk_idle,
  input  logic [N_TRK*(ADDR_W-LINE_OFF)-1:0] trk_line,
  output logic [N_TRK-1:0]                  sel_oh
`ifdef BCAST_DISPATCH_STALL_CNT_EN
  ,
  output logic [15:0]                       stall_cnt
`endif
);

  localparam int TAG_W = ADDR_W - LINE_OFF;

  typedef enum logic {HEAD = 1'b0, BODY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [N_TRK-1:0] lock_q, lock_d;
  logic [4:0]       beats_q, beats_d;
  logic [N_TRK-1:0] hit, idle_sel, sel;
  logic [TAG_W-1:0] tag;
  logic [4:0]       beats;
  logic             rdy, acc, first;

  assign tag = in_a_address[ADDR_W-1:LINE_OFF];

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_TRK; i++)
      hit[i] = ~trk_idle[i] &
               (trk_line[i*TAG_W +: TAG_W] == tag);
  end

  always_comb begin
    idle_sel = '0;
    for (int i = N_TRK - 1; i >= 0; i--)
      if (trk_idle[i]) idle_sel = '0 | (N_TRK'(1) << i);
  end

  // Opcodes 0..3 carry data; larger-than-beat payloads span 2^(size-log2beat).
  always_comb begin
    beats = 5'd1;
    if (!in_a_opcode[2] && in_a_size > 3'(BEAT_LOG2))
      beats = 5'd1 << (in_a_size - 3'(BEAT_LOG2));
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    beats_d = beats_q;
    sel     = '0;
    first   = 1'b0;
    unique case (state_q)
      HEAD: begin
        first = 1'b1;
        if (hit == '0) sel = idle_sel;
      end
      BODY: sel = lock_q;
    endcase
    if (!reset) sel = '0;
    rdy = |(sel & trk_a_ready);
    acc = in_a_valid & rdy;
    unique case (state_q)
      HEAD: begin
        if (acc && beats > 5'd1) begin
          lock_d  = sel;
          beats_d = beats - 5'd1;
          state_d = BODY;
        end
      end
      BODY: begin
        if (acc) begin
          beats_d = beats_q - 5'd1;
          if (beats_q == 5'd1) state_d = HEAD;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= HEAD;
      lock_q  <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      beats_q <= beats_d;
    end
  end

  assign sel_oh      = sel;
  assign in_a_ready  = rdy;
  assign trk_a_first = first;
  assign trk_a_valid = sel & {N_TRK{in_a_valid}};

`ifdef BCAST_DISPATCH_STALL_CNT_EN
  logic [15:0] stall_q;
  logic [7:0]  quiet_q;
  logic        stall_inc;

  assign stall_inc = (state_q == HEAD) & in_a_valid & (|hit);

  // A long idle client (256 quiet cycles) starts a fresh stall window.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      quiet_q <= '0;
    end else if (!in_a_valid) begin
      if (quiet_q == 8'hFF) begin
        quiet_q <= '0;
        stall_q <= '0;
      end else begin
        quiet_q <= quiet_q + 8'd1;
      end
    end else begin
      quiet_q <= '0;
      if (stall_inc && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

  logic unused;
  assign unused = ^{in_a_address[LINE_OFF-1:0], in_a_opcode[1:0]};

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (reset) begin
      assert ($onehot0(sel_oh));
      if (state_q == BODY)
        assert (in_a_ready == |(lock_q & trk_a_ready));
      if (state_q == HEAD && in_a_valid)
        assert ($onehot0(hit));
    end
  end
`endif

endmodule
